// File: rtl/snn_pkg.sv
// Shared types and constants for the parametrised spiking-net inference core.
// Holds the controller state encoding and the fixed-point activation constants.
// Imported by the core and by the MAC/rectifier datapath.
package snn_pkg;

    typedef enum logic [3:0] {
        S_IDLE,
        S_HID_MAC,
        S_HID_DRAIN,
        S_HID_LUT,
        S_HID_WR,
        S_OUT_MAC,
        S_OUT_DRAIN,
        S_OUT_LUT,
        S_OUT_CMP,
        S_DONE
    } state_t;

    // Activation value used for a lit input pixel
    localparam logic [7:0]  Q_ONE      = 8'h7F;
    // Bias that centres the signed rectified sum in the LUT address space
    localparam logic [10:0] LUT_OFFSET = 11'h400;
    // Clamp codes for sums outside the 11-bit window
    localparam logic [10:0] SAT_POS    = 11'h3FF;
    localparam logic [10:0] SAT_NEG    = 11'h400;
    // Most negative signed 8-bit score, seeds the argmax search
    localparam logic [7:0]  SCORE_MIN  = 8'h80;

endpackage

// File: rtl/snn_mac_sat.sv
// Signed 8x8 multiply-accumulate with synchronous clear, plus rectifier to LUT address.
// Latency: product lands in the accumulator at the edge where en_i is high; lut_addr_o is combinational from it.
// No backpressure: accumulates whenever en_i is asserted.
module snn_mac_sat
    import snn_pkg::*;
#(
    parameter int ACC_W = 26
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        clr_i,
    input  logic        en_i,
    input  logic [7:0]  a_i,
    input  logic [7:0]  b_i,
    output logic [10:0] lut_addr_o
);

    logic signed [15:0]       prod;
    logic        [ACC_W-1:0]  acc_q;
    logic        [ACC_W-1:0]  acc_d;
    logic signed [ACC_W-1:0]  acc_hi;
    logic        [10:0]       sat;

    assign prod = $signed(a_i) * $signed(b_i);

    // Next accumulator value: running sum plus sign-extended product
    always_comb begin
        acc_d = acc_q + {{(ACC_W-16){prod[15]}}, prod};
    end

    // Accumulator register; clear has priority over accumulate
    always_ff @(posedge clk) begin
        if (rst || clr_i) begin
            acc_q <= '0;
        end else if (en_i) begin
            acc_q <= acc_d;
        end
    end

    // Everything above bit 16 must be pure sign extension, otherwise clamp
    assign acc_hi = $signed(acc_q) >>> 17;

    // Rectify the sum into the 11-bit signed window acc[17:7]
    always_comb begin
        sat = acc_q[17:7];
        if (!acc_q[ACC_W-1] && (acc_hi != '0)) begin
            sat = SAT_POS;
        end else if (acc_q[ACC_W-1] && (acc_hi != '1)) begin
            sat = SAT_NEG;
        end
        lut_addr_o = sat + LUT_OFFSET;
    end

endmodule

// File: rtl/snn_core_param.sv
// Two-layer MAC inference core over a 1-bit image with on-chip argmax of the outputs.
// Latency: done after N_HID*(N_IN+3) + N_OUT*(N_HID+3) cycles from the start edge.
// No backpressure: memories answer one cycle after each address; start is ignored while busy.
module snn_core_param
    import snn_pkg::*;
#(
    parameter int N_IN  = 784,
    parameter int N_HID = 32,
    parameter int N_OUT = 10,
    parameter int ACC_W = 26
) (
    input  logic                                      clk,
    input  logic                                      rst,
    input  logic                                      start,
    input  logic                                      q_input,
    output logic [$clog2(N_IN)-1:0]                   addr_input_unit,
    output logic [$clog2(N_HID*N_IN+N_OUT*N_HID)-1:0] wt_addr,
    input  logic [7:0]                                wt_data,
    output logic [10:0]                               lut_addr,
    input  logic [7:0]                                lut_data,
    output logic                                      busy,
    output logic                                      done,
    output logic [$clog2(N_OUT)-1:0]                  digit,
    output logic [7:0]                                score
);

    localparam int AW  = $clog2(N_IN);
    localparam int WAW = $clog2(N_HID*N_IN + N_OUT*N_HID);
    localparam int DW  = $clog2(N_OUT);
    localparam int HW  = (N_HID > 1) ? $clog2(N_HID) : 1;
    localparam int IW  = $clog2((N_IN > N_HID) ? N_IN : N_HID);

    state_t          state_q;
    logic [IW-1:0]   i_q;
    logic [HW-1:0]   h_q;
    logic [DW-1:0]   o_q;
    logic [WAW-1:0]  wt_addr_q;
    logic [7:0]      best_q;
    logic [DW-1:0]   idx_q;
    logic [7:0]      hsel_q;
    logic            busy_q;
    logic            done_q;
    logic [DW-1:0]   digit_q;
    logic [7:0]      score_q;
    logic [7:0]      hid_q [N_HID];

    logic            mac_en;
    logic            mac_clr;
    logic [7:0]      mac_a;
    logic            win;

    assign addr_input_unit = i_q[AW-1:0];
    assign wt_addr         = wt_addr_q;
    assign busy            = busy_q;
    assign done            = done_q;
    assign digit           = digit_q;
    assign score           = score_q;

    // Strictly greater keeps the lower index on ties
    assign win = $signed(lut_data) > $signed(best_q);

    // The first MAC cycle of each unit sees stale memory data, so it is not accumulated
    always_comb begin
        mac_en  = 1'b0;
        mac_clr = 1'b0;
        mac_a   = '0;
        case (state_q)
            S_IDLE:      mac_clr = start;
            S_HID_MAC: begin
                mac_en = (i_q != '0);
                mac_a  = q_input ? Q_ONE : 8'h00;
            end
            S_HID_DRAIN: begin
                mac_en = 1'b1;
                mac_a  = q_input ? Q_ONE : 8'h00;
            end
            S_HID_WR:    mac_clr = 1'b1;
            S_OUT_MAC: begin
                mac_en = (i_q != '0);
                mac_a  = hsel_q;
            end
            S_OUT_DRAIN: begin
                mac_en = 1'b1;
                mac_a  = hsel_q;
            end
            S_OUT_CMP:   mac_clr = 1'b1;
            default:     ;
        endcase
    end

    snn_mac_sat #(
        .ACC_W (ACC_W)
    ) u_mac (
        .clk        (clk),
        .rst        (rst),
        .clr_i      (mac_clr),
        .en_i       (mac_en),
        .a_i        (mac_a),
        .b_i        (wt_data),
        .lut_addr_o (lut_addr)
    );

    // Hidden activation file; contents are only meaningful within a run
    always_ff @(posedge clk) begin
        if (state_q == S_HID_WR) begin
            hid_q[h_q] <= lut_data;
        end
    end

    // Sequencer: hidden layer, output layer with running argmax, then a one-cycle done
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            i_q       <= '0;
            h_q       <= '0;
            o_q       <= '0;
            wt_addr_q <= '0;
            best_q    <= SCORE_MIN;
            idx_q     <= '0;
            hsel_q    <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            digit_q   <= '0;
            score_q   <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        state_q   <= S_HID_MAC;
                        i_q       <= '0;
                        h_q       <= '0;
                        wt_addr_q <= '0;
                        busy_q    <= 1'b1;
                    end
                end
                S_HID_MAC: begin
                    // Hidden weights are contiguous across units, so the address just counts
                    wt_addr_q <= wt_addr_q + WAW'(1);
                    if (i_q == IW'(N_IN-1)) begin
                        i_q     <= '0;
                        state_q <= S_HID_DRAIN;
                    end else begin
                        i_q <= i_q + IW'(1);
                    end
                end
                S_HID_DRAIN: state_q <= S_HID_LUT;
                S_HID_LUT:   state_q <= S_HID_WR;
                S_HID_WR: begin
                    if (h_q == HW'(N_HID-1)) begin
                        state_q <= S_OUT_MAC;
                        o_q     <= '0;
                        best_q  <= SCORE_MIN;
                        idx_q   <= '0;
                    end else begin
                        h_q     <= h_q + HW'(1);
                        state_q <= S_HID_MAC;
                    end
                end
                S_OUT_MAC: begin
                    // Operand is staged alongside the ROM read so both arrive together
                    hsel_q    <= hid_q[i_q[HW-1:0]];
                    wt_addr_q <= wt_addr_q + WAW'(1);
                    if (i_q == IW'(N_HID-1)) begin
                        i_q     <= '0;
                        state_q <= S_OUT_DRAIN;
                    end else begin
                        i_q <= i_q + IW'(1);
                    end
                end
                S_OUT_DRAIN: state_q <= S_OUT_LUT;
                S_OUT_LUT:   state_q <= S_OUT_CMP;
                S_OUT_CMP: begin
                    if (win) begin
                        best_q <= lut_data;
                        idx_q  <= o_q;
                    end
                    if (o_q == DW'(N_OUT-1)) begin
                        // Publish the final comparison directly so results are valid with done
                        state_q <= S_DONE;
                        done_q  <= 1'b1;
                        busy_q  <= 1'b0;
                        digit_q <= win ? o_q : idx_q;
                        score_q <= win ? lut_data : best_q;
                    end else begin
                        o_q     <= o_q + DW'(1);
                        state_q <= S_OUT_MAC;
                    end
                end
                S_DONE: begin
                    done_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_snn_core_param.sv
// Directed bench for snn_core_param: three instances (small, saturation, default size)
// with registered ROM/LUT/image models answering one cycle after each address.
module tb_snn_core_param;

    logic clk;
    logic [2:0] start_v;
    logic rst_a, rst_b, rst_c;
    int checks;
    int errors;

    // Instance A: N_IN=4, N_HID=2, N_OUT=3
    logic        q_a;
    logic [1:0]  addr_a;
    logic [3:0]  wt_addr_a;
    logic [7:0]  wt_a;
    logic [10:0] lut_addr_a;
    logic [7:0]  lut_a;
    logic        busy_a, done_a;
    logic [1:0]  digit_a;
    logic [7:0]  score_a;
    logic [7:0]  out_w [3];

    // Instance B: N_IN=16, N_HID=2, N_OUT=2
    logic        q_b;
    logic [3:0]  addr_b;
    logic [5:0]  wt_addr_b;
    logic [7:0]  wt_b;
    logic [10:0] lut_addr_b;
    logic [7:0]  lut_b;
    logic        busy_b, done_b;
    logic [0:0]  digit_b;
    logic [7:0]  score_b;
    logic [7:0]  hw_b;

    // Instance C: default parameters
    logic        q_c;
    logic [9:0]  addr_c;
    logic [14:0] wt_addr_c;
    logic [7:0]  wt_c;
    logic [10:0] lut_addr_c;
    logic [7:0]  lut_c;
    logic        busy_c, done_c;
    logic [3:0]  digit_c;
    logic [7:0]  score_c;

    snn_core_param #(.N_IN(4), .N_HID(2), .N_OUT(3), .ACC_W(26)) dut_a (
        .clk(clk), .rst(rst_a), .start(start_v[0]), .q_input(q_a),
        .addr_input_unit(addr_a), .wt_addr(wt_addr_a), .wt_data(wt_a),
        .lut_addr(lut_addr_a), .lut_data(lut_a), .busy(busy_a), .done(done_a),
        .digit(digit_a), .score(score_a));

    snn_core_param #(.N_IN(16), .N_HID(2), .N_OUT(2), .ACC_W(26)) dut_b (
        .clk(clk), .rst(rst_b), .start(start_v[1]), .q_input(q_b),
        .addr_input_unit(addr_b), .wt_addr(wt_addr_b), .wt_data(wt_b),
        .lut_addr(lut_addr_b), .lut_data(lut_b), .busy(busy_b), .done(done_b),
        .digit(digit_b), .score(score_b));

    snn_core_param dut_c (
        .clk(clk), .rst(rst_c), .start(start_v[2]), .q_input(q_c),
        .addr_input_unit(addr_c), .wt_addr(wt_addr_c), .wt_data(wt_c),
        .lut_addr(lut_addr_c), .lut_data(lut_c), .busy(busy_c), .done(done_c),
        .digit(digit_c), .score(score_c));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [7:0] lutf(input logic [10:0] a);
        logic [10:0] t;
        t = a - 11'h400;
        return (a >= 11'h400) ? t[7:0] : 8'h00;
    endfunction

    function automatic logic [7:0] wa(input logic [3:0] a);
        int k;
        if (a < 4'd8) return 8'd1;
        k = (int'(a) - 8) / 2;
        if (k > 2) return 8'd0;
        return out_w[k];
    endfunction

    // Memory models: synchronous reads, data valid one cycle after the address
    always @(posedge clk) begin
        q_a   <= (addr_a <= 2'd3);
        wt_a  <= wa(wt_addr_a);
        lut_a <= lutf(lut_addr_a);
        q_b   <= (addr_b <= 4'd15);
        wt_b  <= (wt_addr_b < 6'd32) ? hw_b : 8'd1;
        lut_b <= lutf(lut_addr_b);
        q_c   <= (addr_c == 10'h3FF);
        wt_c  <= 8'(wt_addr_c);
        lut_c <= lutf(lut_addr_c);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp_v);
        end
    endtask

    // Start one run on instance sel, record the hidden LUT address of units 0 and 1,
    // the done latency in edges after the start edge, and done pulses seen.
    task automatic run(input int sel, input bit spam, input int n_in, input int limit,
                       output int lat, output int ndone, output logic bsy,
                       output logic [10:0] cap0, output logic [10:0] cap1);
        logic d;
        logic b;
        logic [10:0] la;
        lat = -1; ndone = 0; bsy = 1'b1; cap0 = '0; cap1 = '0;
        start_v[sel] = 1'b1;
        tick();
        start_v[sel] = spam;
        for (int n = 1; n <= limit; n++) begin
            tick();
            case (sel)
                0:       begin d = done_a; b = busy_a; la = lut_addr_a; end
                1:       begin d = done_b; b = busy_b; la = lut_addr_b; end
                default: begin d = done_c; b = busy_c; la = lut_addr_c; end
            endcase
            if (n == n_in + 1) cap0 = la;
            if (n == 2*n_in + 4) cap1 = la;
            if (d) begin
                ndone++;
                lat = n;
                bsy = b;
                break;
            end
        end
        start_v[sel] = 1'b0;
        if (lat >= 0) begin
            for (int k = 0; k < 3; k++) begin
                tick();
                case (sel)
                    0:       d = done_a;
                    1:       d = done_b;
                    default: d = done_c;
                endcase
                if (d) ndone++;
            end
        end
    endtask

    initial begin
        int lat, nd;
        logic bsy;
        logic [10:0] c0, c1;
        checks = 0; errors = 0;
        start_v = '0;
        rst_a = 1'b1; rst_b = 1'b1; rst_c = 1'b1;
        out_w[0] = 8'd10; out_w[1] = 8'd100; out_w[2] = 8'd50;
        hw_b = 8'd127;
        repeat (3) tick();

        // Reset state
        chk("rst_busy",  busy_a, 0);
        chk("rst_done",  done_a, 0);
        chk("rst_digit", digit_a, 0);
        chk("rst_score", score_a, 0);
        chk("rst_lut",   lut_addr_a, 32'h400);
        chk("rst_wtad",  wt_addr_a, 0);
        chk("rst_pix",   addr_a, 0);
        rst_a = 1'b0; rst_b = 1'b0; rst_c = 1'b0;
        tick();

        // Small network argmax
        run(0, 0, 4, 200, lat, nd, bsy, c0, c1);
        chk("s1_hid0_lut", c0, 32'h403);
        chk("s1_hid1_lut", c1, 32'h403);
        chk("s1_latency",  lat, 29);
        chk("s1_ndone",    nd, 1);
        chk("s1_digit",    digit_a, 1);
        chk("s1_score",    score_a, 4);
        chk("s1_busy_done", bsy, 0);

        // Start held high for the whole run
        run(0, 1, 4, 200, lat, nd, bsy, c0, c1);
        chk("s4_latency",   lat, 29);
        chk("s4_ndone",     nd, 1);
        chk("s4_busy_done", bsy, 0);
        chk("s4_digit",     digit_a, 1);
        chk("s4_idle_busy", busy_a, 0);

        // Reset 10 cycles into a run
        run(0, 0, 4, 10, lat, nd, bsy, c0, c1);
        chk("s5_no_done_pre", nd, 0);
        chk("s5_busy_pre",    busy_a, 1);
        rst_a = 1'b1;
        tick();
        chk("s5_busy",  busy_a, 0);
        chk("s5_done",  done_a, 0);
        chk("s5_digit", digit_a, 0);
        chk("s5_score", score_a, 0);
        tick();
        chk("s5_done2", done_a, 0);
        rst_a = 1'b0;
        repeat (3) tick();
        chk("s5_idle_done", done_a, 0);
        run(0, 0, 4, 200, lat, nd, bsy, c0, c1);
        chk("s5_re_latency", lat, 29);
        chk("s5_re_digit",   digit_a, 1);
        chk("s5_re_score",   score_a, 4);

        // Tie between equal outputs keeps the lower index
        out_w[0] = 8'd100; out_w[1] = 8'd100; out_w[2] = 8'd100;
        run(0, 0, 4, 200, lat, nd, bsy, c0, c1);
        chk("s2_latency", lat, 29);
        chk("s2_digit",   digit_a, 0);
        chk("s2_score",   score_a, 4);

        // Saturation, positive then negative
        hw_b = 8'd127;
        run(1, 0, 16, 200, lat, nd, bsy, c0, c1);
        chk("s3_pos_hid0", c0, 32'h7FF);
        chk("s3_pos_hid1", c1, 32'h7FF);
        chk("s3_pos_lat",  lat, 48);
        chk("s3_pos_digit", digit_b, 0);
        chk("s3_pos_score", score_b, 0);
        hw_b = 8'h80;
        run(1, 0, 16, 200, lat, nd, bsy, c0, c1);
        chk("s3_neg_hid0", c0, 32'h000);
        chk("s3_neg_hid1", c1, 32'h000);
        chk("s3_neg_lat",  lat, 48);

        // Default-size network, blank image
        run(2, 0, 784, 30000, lat, nd, bsy, c0, c1);
        chk("s6_hid0_lut", c0, 32'h400);
        chk("s6_hid1_lut", c1, 32'h400);
        chk("s6_latency",  lat, 25534);
        chk("s6_ndone",    nd, 1);
        chk("s6_digit",    digit_c, 0);
        chk("s6_score",    score_c, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
